judge_unit: RTL and testbench

Judge stage for the tic-tac-toe game flow. On a `make_judge_req` pulse from `game_manager`, it latches the current `board_a`/`board_b`, scans every winning line one per clock, and returns registered `end_of_game`/`win_a`/`win_b`. It sits directly downstream of `game_manager`, which drives its request and board inputs and consumes its result outputs. Latency is fixed and independent of board contents.

---
 rtl/tic_tac_toe_pkg.sv | 31 +++
 rtl/judge_line_check.sv | 16 +
 rtl/judge_unit.sv | 100 ++++++++++
 tb/tb_judge_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/tic_tac_toe_pkg.sv
// Shared types and line-geometry helpers for the tic-tac-toe judge.
// Masks are returned at a fixed maximum width; callers keep the low ROWS*COLS bits.
package tic_tac_toe_pkg;

   typedef enum logic [1:0] {IDLE, SCAN, DONE} judge_state_t;

   localparam int unsigned JUDGE_MAX_CELLS = 64;
   typedef logic [JUDGE_MAX_CELLS-1:0] judge_mask_t;

   function automatic int unsigned judge_num_lines(input int unsigned rows, input int unsigned cols);
      return rows + cols + ((rows == cols) ? 2 : 0);
   endfunction

   // Line order: rows, columns, then main and anti diagonal (square boards only).
   function automatic judge_mask_t judge_line_mask(input int unsigned rows, input int unsigned cols,
                                                   input int unsigned idx);
      judge_mask_t m;
      m = '0;
      if (idx < rows) begin
         for (int unsigned c = 0; c < cols; c++) m[idx*cols + c] = 1'b1;
      end else if (idx < rows + cols) begin
         for (int unsigned r = 0; r < rows; r++) m[r*cols + (idx - rows)] = 1'b1;
      end else if (idx == rows + cols) begin
         for (int unsigned r = 0; r < rows; r++) m[r*cols + r] = 1'b1;
      end else begin
         for (int unsigned r = 0; r < rows; r++) m[r*cols + (cols - 1 - r)] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/judge_line_check.sv
// Combinational test of one winning line: a player owns the line when every
// masked cell is set in that player's board.
module judge_line_check #(
   parameter int unsigned W = 9
) (
   input  logic [W-1:0] mask,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         full_a,
   output logic         full_b
);

   assign full_a = &(a | ~mask);
   assign full_b = &(b | ~mask);

endmodule

// File: rtl/judge_unit.sv
// Judge stage: latches both boards on request, scans every winning line one per
// clock with a single line checker, then registers win/end-of-game results.
module judge_unit
   import tic_tac_toe_pkg::*;
#(
   parameter int unsigned ROWS = 3,
   parameter int unsigned COLS = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 make_judge_req,
   output logic                 make_judge_ready,
   input  logic [ROWS*COLS-1:0] board_a,
   input  logic [ROWS*COLS-1:0] board_b,
   output logic                 end_of_game,
   output logic                 win_a,
   output logic                 win_b
);

   localparam int unsigned N    = ROWS * COLS;
   localparam int unsigned L    = judge_num_lines(ROWS, COLS);
   localparam int unsigned IW   = (L > 1) ? $clog2(L) : 1;
   localparam logic [IW-1:0] LAST = IW'(L - 1);

   judge_state_t  state_q;
   logic [N-1:0]  a_q, b_q;
   logic [IW-1:0] idx_q;
   logic          hit_a_q, hit_b_q;
   logic          hit_a_d, hit_b_d;
   logic          full_a, full_b;
   logic [N-1:0]  line_mask;
   logic [N-1:0]  mask_tbl [L];

   // Line masks are elaboration-time constants; idx_q just selects one.
   for (genvar g = 0; g < L; g++) begin : g_mask
      localparam judge_mask_t M = judge_line_mask(ROWS, COLS, g);
      assign mask_tbl[g] = M[N-1:0];
   end

   assign line_mask = mask_tbl[idx_q];

   judge_line_check #(.W(N)) u_line_check (
      .mask   (line_mask),
      .a      (a_q),
      .b      (b_q),
      .full_a (full_a),
      .full_b (full_b)
   );

   assign hit_a_d = hit_a_q | full_a;
   assign hit_b_d = hit_b_q | full_b;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q          <= IDLE;
         make_judge_ready <= 1'b1;
         end_of_game      <= 1'b0;
         win_a            <= 1'b0;
         win_b            <= 1'b0;
         a_q              <= '0;
         b_q              <= '0;
         idx_q            <= '0;
         hit_a_q          <= 1'b0;
         hit_b_q          <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (make_judge_req) begin
                  a_q              <= board_a;
                  b_q              <= board_b;
                  hit_a_q          <= 1'b0;
                  hit_b_q          <= 1'b0;
                  idx_q            <= '0;
                  make_judge_ready <= 1'b0;
                  state_q          <= SCAN;
               end
            end
            SCAN: begin
               hit_a_q <= hit_a_d;
               hit_b_q <= hit_b_d;
               if (idx_q == LAST) begin
                  idx_q   <= '0;
                  state_q <= DONE;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            DONE: begin
               win_a            <= hit_a_q;
               win_b            <= hit_b_q;
               end_of_game      <= hit_a_q | hit_b_q | (&(a_q | b_q));
               make_judge_ready <= 1'b1;
               state_q          <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_judge_unit.sv
// Self-checking bench for judge_unit: transaction-level reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_judge_unit;

   localparam int ROWS = 3;
   localparam int COLS = 3;
   localparam int LAT  = 9;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       make_judge_req = 1'b0;
   logic [8:0] board_a = '0;
   logic [8:0] board_b = '0;
   logic       make_judge_ready, end_of_game, win_a, win_b;

   int vectors = 0;
   int miscompares = 0;

   judge_unit #(.ROWS(ROWS), .COLS(COLS)) dut (
      .clk              (clk),
      .reset            (reset),
      .make_judge_req   (make_judge_req),
      .make_judge_ready (make_judge_ready),
      .board_a          (board_a),
      .board_b          (board_b),
      .end_of_game      (end_of_game),
      .win_a            (win_a),
      .win_b            (win_b)
   );

   always #5 clk = ~clk;

   // Returns {end_of_game, win_a, win_b} for a 3x3 board pair.
   function automatic logic [2:0] ref_judge(input logic [8:0] a, input logic [8:0] b);
      logic [8:0] s;
      bit w, wa, wb;
      wa = 0;
      wb = 0;
      for (int p = 0; p < 2; p++) begin
         s = (p == 0) ? a : b;
         w = 0;
         for (int r = 0; r < 3; r++) if (s[r*3] && s[r*3+1] && s[r*3+2]) w = 1;
         for (int c = 0; c < 3; c++) if (s[c] && s[c+3] && s[c+6]) w = 1;
         if (s[0] && s[4] && s[8]) w = 1;
         if (s[2] && s[4] && s[6]) w = 1;
         if (p == 0) wa = w; else wb = w;
      end
      return {wa | wb | (&(a | b)), wa, wb};
   endfunction

   logic       m_ready = 1'b1;
   logic [2:0] m_res   = '0;
   logic [2:0] m_pend  = '0;
   int         m_left  = 0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_ready <= 1'b1;
         m_res   <= '0;
         m_left  <= 0;
      end else if (m_ready) begin
         if (make_judge_req) begin
            m_ready <= 1'b0;
            m_pend  <= ref_judge(board_a, board_b);
            m_left  <= LAT - 1;
         end
      end else if (m_left == 0) begin
         m_ready <= 1'b1;
         m_res   <= m_pend;
      end else begin
         m_left <= m_left - 1;
      end
   end

   always @(negedge clk) begin
      vectors++;
      if ({make_judge_ready, end_of_game, win_a, win_b} !== {m_ready, m_res}) begin
         miscompares++;
         $display("FAIL cycle-compare t=%0t rdy/eog/wa/wb got=%b required=%b",
                  $time, {make_judge_ready, end_of_game, win_a, win_b}, {m_ready, m_res});
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic wait_ready(input string name);
      int guard;
      guard = 0;
      while (!make_judge_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check({name, " ready-timeout"}, 32'(guard < 100), 1);
   endtask

   task automatic run_judge(input string name, input logic [8:0] a, input logic [8:0] b,
                            input logic [2:0] exp, input bit chg, input bit req2);
      int n;
      wait_ready(name);
      board_a = a;
      board_b = b;
      make_judge_req = 1'b1;
      @(negedge clk);
      make_judge_req = 1'b0;
      if (chg) begin
         board_a = 9'b000_000_111;
         board_b = '0;
      end
      n = 0;
      while (!make_judge_ready && n < 50) begin
         n++;
         make_judge_req = (req2 && n == 3);
         @(negedge clk);
      end
      make_judge_req = 1'b0;
      check({name, " latency"}, n, LAT);
      check({name, " result"}, {end_of_game, win_a, win_b}, exp);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int n;
      logic [8:0] ra, rb;

      check("model row0-A",   ref_judge(9'b000_000_111, 9'b000_011_000), 3'b110);
      check("model col1-B",   ref_judge(9'b000_100_001, 9'b010_010_010), 3'b101);
      check("model draw",     ref_judge(9'b110_001_101, 9'b001_110_010), 3'b100);
      check("model both-win", ref_judge(9'b111_000_000, 9'b000_000_111), 3'b111);

      #1 reset = 1'b0;
      repeat (2) @(negedge clk);
      check("reset state", {make_judge_ready, end_of_game, win_a, win_b}, 4'b1000);
      reset = 1'b1;
      @(negedge clk);

      run_judge("empty",      9'b000_000_000, 9'b000_000_000, 3'b000, 0, 0);
      run_judge("draw",       9'b110_001_101, 9'b001_110_010, 3'b100, 0, 0);
      run_judge("diag-A",     9'b100_010_001, 9'b000_100_010, 3'b110, 0, 0);
      run_judge("col1-B",     9'b000_100_001, 9'b010_010_010, 3'b101, 0, 0);
      run_judge("late-board", 9'b000_000_011, 9'b000_000_000, 3'b000, 1, 0);
      run_judge("busy-req",   9'b000_000_000, 9'b111_000_000, 3'b101, 0, 1);
      run_judge("anti-A",     9'b001_010_100, 9'b000_001_010, 3'b110, 0, 0);
      run_judge("row0-A",     9'b000_000_111, 9'b000_011_000, 3'b110, 0, 0);

      // Reset in the middle of a scan discards the partial judgement at once.
      wait_ready("mid-reset");
      board_a = 9'b000_111_000;
      board_b = '0;
      make_judge_req = 1'b1;
      @(negedge clk);
      make_judge_req = 1'b0;
      repeat (4) @(negedge clk);
      #2 reset = 1'b0;
      #1 check("mid-reset outputs", {make_judge_ready, end_of_game, win_a, win_b}, 4'b1000);
      @(negedge clk);
      reset = 1'b1;
      run_judge("after-reset", 9'b000_100_001, 9'b010_010_010, 3'b101, 0, 0);

      // Request held high restarts as soon as ready returns.
      wait_ready("held-req");
      board_a = 9'b000_000_111;
      board_b = '0;
      make_judge_req = 1'b1;
      @(negedge clk);
      n = 0;
      while (!make_judge_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      check("held-req latency", n, LAT);
      check("held-req result", {end_of_game, win_a, win_b}, 3'b110);
      @(negedge clk);
      check("held-req restart", make_judge_ready, 0);
      make_judge_req = 1'b0;
      wait_ready("held-req end");

      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         ra = 9'($urandom);
         rb = 9'($urandom);
         if ($urandom_range(0, 1) == 0) rb = rb & ~ra;
         board_a = ra;
         board_b = rb;
         make_judge_req = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 299) == 0) begin
            #2 reset = 1'b0;
            @(negedge clk);
            reset = 1'b1;
         end
      end
      make_judge_req = 1'b0;
      wait_ready("final");
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
